// File: rtl/tlp_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tlp_packetizer_if
//  Description : Request-side and TLP-side valid/ready bundle for tlp_packetizer.
//  Revision    : 1.0  initial release
// ============================================================================
interface tlp_packetizer_if;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [1:0]     req_cmd_i;
    logic [2:0]     req_tc_i;
    logic [9:0]     req_length_i;
    logic [15:0]    req_requestID_i;
    logic [15:0]    req_completID_i;
    logic [31:0]    req_addr_i;
    logic [511:0]   req_data_i;
    logic           tlp_valid_o;
    logic           tlp_ready_i;
    logic [1023:0]  tlp_data_o;

    modport master (
        output req_valid_i, req_cmd_i, req_tc_i, req_length_i, req_requestID_i,
               req_completID_i, req_addr_i, req_data_i, tlp_ready_i,
        input  req_ready_o, tlp_valid_o, tlp_data_o
    );

    modport slave (
        input  req_valid_i, req_cmd_i, req_tc_i, req_length_i, req_requestID_i,
               req_completID_i, req_addr_i, req_data_i, tlp_ready_i,
        output req_ready_o, tlp_valid_o, tlp_data_o
    );
endinterface
`default_nettype wire

// File: rtl/tlp_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tlp_packetizer
//  Description : TX TLP builder; queues MRD/MWR/CPL/CPLD requests in a small
//                FIFO and encodes the head entry into a 1024-bit TLP word.
//  Revision    : 1.0  initial release
// ============================================================================
module tlp_packetizer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tlp_packetizer_if.slave     bus,
    output logic [CNT_W-1:0]    tlp_cnt_o
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] c_CMD_MRD  = 2'd0;
    localparam logic [1:0] c_CMD_MWR  = 2'd1;
    localparam logic [1:0] c_CMD_CPL  = 2'd2;
    localparam logic [1:0] c_CMD_CPLD = 2'd3;

    typedef struct packed {
        logic [1:0]   cmd;
        logic [2:0]   tc;
        logic [9:0]   len;
        logic [15:0]  rid;
        logic [15:0]  id;
        logic [511:0] data;
    } entry_t;

    entry_t               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [CNT_W-1:0]     r_tlp_cnt;

    logic                 w_req_ready;
    logic                 w_tlp_valid;
    logic                 w_push;
    logic                 w_pop;
    entry_t               w_wr_entry;
    entry_t               w_head;
    logic [1023:0]        w_tlp_data;
    logic                 w_unused_addr;

    assign w_req_ready = (r_count < c_FULL);
    assign w_tlp_valid = (r_count != '0);
    assign w_push      = bus.req_valid_i & w_req_ready;
    assign w_pop       = w_tlp_valid & bus.tlp_ready_i;

    assign bus.req_ready_o = w_req_ready;
    assign bus.tlp_valid_o = w_tlp_valid;
    assign bus.tlp_data_o  = w_tlp_data;
    assign tlp_cnt_o       = r_tlp_cnt;

    // Only the low address half is encoded into the header.
    assign w_unused_addr = &{1'b0, bus.req_addr_i[31:16]};

    // Completions carry the completer ID where requests carry the address;
    // payload is kept only for the data-bearing commands.
    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.cmd  = bus.req_cmd_i;
        w_wr_entry.tc   = bus.req_tc_i;
        w_wr_entry.len  = bus.req_length_i;
        w_wr_entry.rid  = bus.req_requestID_i;
        w_wr_entry.id   = (bus.req_cmd_i == c_CMD_CPL || bus.req_cmd_i == c_CMD_CPLD)
                          ? bus.req_completID_i : bus.req_addr_i[15:0];
        w_wr_entry.data = (bus.req_cmd_i == c_CMD_MWR || bus.req_cmd_i == c_CMD_CPLD)
                          ? bus.req_data_i : '0;
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_tlp_data = '0;
        if (w_tlp_valid) begin
            unique case (w_head.cmd)
                c_CMD_MRD:  w_tlp_data[607:600] = 8'h00;
                c_CMD_MWR:  w_tlp_data[607:600] = 8'h40;
                c_CMD_CPL:  w_tlp_data[607:600] = 8'h0A;
                c_CMD_CPLD: w_tlp_data[607:600] = 8'h4A;
                default:    w_tlp_data[607:600] = 8'h00;
            endcase
            w_tlp_data[598:596] = w_head.tc;
            w_tlp_data[585:576] = w_head.len;
            w_tlp_data[575:560] = w_head.rid;
            w_tlp_data[543:528] = w_head.id;
            w_tlp_data[511:0]   = w_head.data;
        end
    end

    // Storage is not reset; clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tlp_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tlp_cnt <= r_tlp_cnt + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlp_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlp_packetizer
//  Description : Directed scoreboard bench for tlp_packetizer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tlp_packetizer;

    localparam int TB_DEPTH = 4;
    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [TB_CNT_W-1:0] tlp_cnt;

    tlp_packetizer_if bus ();

    tlp_packetizer #(
        .FIFO_DEPTH (TB_DEPTH),
        .CNT_W      (TB_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tlp_cnt_o (tlp_cnt)
    );

    always #5 clk = ~clk;

    int                  n_pass = 0;
    int                  n_chk  = 0;
    int                  n_fail = 0;
    int                  n_in   = 0;
    int                  n_out  = 0;
    bit                  acc;
    logic [TB_CNT_W-1:0] cnt_model = '0;
    logic [1023:0]       cur_exp;
    logic [1023:0]       held;
    logic [1023:0]       sb [$];

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: observed condition not met, expected it met", tag);
    endtask

    function automatic logic [1023:0] enc(input logic [1:0] cmd, input logic [2:0] tc,
                                          input logic [9:0] len, input logic [15:0] rid,
                                          input logic [15:0] cid, input logic [31:0] addr,
                                          input logic [511:0] data);
        logic [1023:0] w;
        w = '0;
        case (cmd)
            2'd0:    w[607:605] = 3'b000;
            2'd1:    w[607:605] = 3'b010;
            2'd2:    begin w[607:605] = 3'b000; w[604:600] = 5'b01010; end
            default: begin w[607:605] = 3'b010; w[604:600] = 5'b01010; end
        endcase
        w[598:596] = tc;
        w[585:576] = len;
        w[575:560] = rid;
        w[543:528] = cmd[1] ? cid : addr[15:0];
        if (cmd == 2'd1 || cmd == 2'd3) w[511:0] = data;
        return w;
    endfunction

    task automatic drive(input logic [1:0] cmd, input logic [2:0] tc, input logic [9:0] len,
                         input logic [15:0] rid, input logic [15:0] cid,
                         input logic [31:0] addr, input logic [511:0] data);
        bus.req_valid_i     = 1'b1;
        bus.req_cmd_i       = cmd;
        bus.req_tc_i        = tc;
        bus.req_length_i    = len;
        bus.req_requestID_i = rid;
        bus.req_completID_i = cid;
        bus.req_addr_i      = addr;
        bus.req_data_i      = data;
        cur_exp             = enc(cmd, tc, len, rid, cid, addr, data);
    endtask

    task automatic drive_rand();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        drive(2'($urandom_range(0, 3)), 3'($urandom), 10'($urandom), 16'($urandom),
              16'($urandom), $urandom, d);
    endtask

    // Called at a falling edge with inputs settled; evaluates the upcoming edge.
    task automatic tick();
        logic [1023:0] e;
        #2;
        chk("tlp_valid", {1023'd0, bus.tlp_valid_o}, {1023'd0, (sb.size() != 0)});
        if (sb.size() == 0) chk("idle_data_zero", bus.tlp_data_o, '0);
        acc = (bus.req_valid_i === 1'b1) && (bus.req_ready_o === 1'b1);
        if (bus.tlp_valid_o === 1'b1 && bus.tlp_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                fail("unexpected_tlp");
            end else begin
                e = sb.pop_front();
                chk("tlp_data", bus.tlp_data_o, e);
                cnt_model++;
                n_out++;
            end
        end
        if (acc) begin
            sb.push_back(cur_exp);
            n_in++;
        end
        @(posedge clk);
        #1;
        chk("tlp_cnt", {1016'd0, tlp_cnt}, {1016'd0, cnt_model});
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        bus.req_valid_i = 1'b0;
        bus.tlp_ready_i = 1'b1;
        for (int i = 0; i < bound && sb.size() != 0; i++) tick();
        if (sb.size() != 0) fail("drain_timeout");
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        #1;
        chk("rst_valid", {1023'd0, bus.tlp_valid_o}, '0);
        chk("rst_cnt", {1016'd0, tlp_cnt}, '0);
        chk("rst_data", bus.tlp_data_o, '0);
        sb.delete();
        cnt_model = '0;
        n_in      = 0;
        n_out     = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {1023'd0, bus.req_ready_o}, 1024'd1);
        @(negedge clk);
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid_i     = 1'b0;
        bus.req_cmd_i       = '0;
        bus.req_tc_i        = '0;
        bus.req_length_i    = '0;
        bus.req_requestID_i = '0;
        bus.req_completID_i = '0;
        bus.req_addr_i      = '0;
        bus.req_data_i      = '0;
        bus.tlp_ready_i     = 1'b0;
        cur_exp             = '0;
        @(negedge clk);
        do_reset();

        // Single MWR: latency, opcode, address, payload, counter
        drive(2'd1, 3'd3, 10'd16, 16'h0100, 16'h0000, 32'hDEAD_BEEF, {64{8'hA5}});
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        chk("mwr_valid", {1023'd0, bus.tlp_valid_o}, 1024'd1);
        chk("mwr_fmt_type", {1016'd0, bus.tlp_data_o[607:600]}, {1016'd0, 8'h40});
        chk("mwr_addr", {1008'd0, bus.tlp_data_o[543:528]}, {1008'd0, 16'hBEEF});
        chk("mwr_data", {512'd0, bus.tlp_data_o[511:0]}, {512'd0, {64{8'hA5}}});
        @(negedge clk);
        drain(8);
        chk("mwr_cnt", {1016'd0, tlp_cnt}, 1024'd1);

        // CPLD then CPL with payload that must be dropped
        bus.tlp_ready_i = 1'b0;
        drive(2'd3, 3'd0, 10'd1, 16'h0100, 16'h0200, 32'h0, {16{32'h1234_5678}});
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        chk("cpld_fmt_type", {1016'd0, bus.tlp_data_o[607:600]}, {1016'd0, 8'h4A});
        chk("cpld_cid", {1008'd0, bus.tlp_data_o[543:528]}, {1008'd0, 16'h0200});
        @(negedge clk);
        drain(8);
        bus.tlp_ready_i = 1'b0;
        drive(2'd2, 3'd5, 10'd0, 16'h0100, 16'h0300, 32'h0000_5555, {512{1'b1}});
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        chk("cpl_fmt_type", {1016'd0, bus.tlp_data_o[607:600]}, {1016'd0, 8'h0A});
        chk("cpl_data_zero", {512'd0, bus.tlp_data_o[511:0]}, '0);
        @(negedge clk);
        drain(8);

        // Fill with ready low, hold a fifth request, then release
        do_reset();
        bus.tlp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, 3'(k), 10'(k + 1), 16'(16'h0A00 + k), 16'h0, 32'(32'h1000 * (k + 1)), '0);
            tick();
            chk("fill_acc", {1023'd0, acc}, 1024'd1);
        end
        chk("full_ready", {1023'd0, bus.req_ready_o}, '0);
        held = bus.tlp_data_o;
        drive(2'd0, 3'd7, 10'd99, 16'hFFFF, 16'h0, 32'h9999, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_not_acc", {1023'd0, acc}, '0);
            chk("head_stable", bus.tlp_data_o, held);
        end
        bus.req_valid_i = 1'b0;
        bus.tlp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("burst_empty", 1024'(sb.size()), '0);
        chk("burst_cnt", {1016'd0, tlp_cnt}, 1024'd4);
        drain(4);

        // Full FIFO with concurrent push and pop
        do_reset();
        bus.tlp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_rand();
            tick();
        end
        bus.tlp_ready_i = 1'b1;
        begin
            int k = 0;
            for (int t = 0; t < 60 && k < 12; t++) begin
                drive_rand();
                tick();
                if (acc) k++;
                if (sb.size() > TB_DEPTH) fail("occupancy_over_depth");
            end
            if (k < 12) fail("pushpop_timeout");
        end
        drain(10);
        chk("pushpop_in_out", 1024'(n_in), 1024'(n_out));

        // Reset while stalled with three entries queued
        do_reset();
        bus.tlp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            tick();
        end
        bus.req_valid_i = 1'b0;
        tick();
        chk("pre_rst_valid", {1023'd0, bus.tlp_valid_o}, 1024'd1);
        do_reset();
        bus.tlp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_cnt", {1016'd0, tlp_cnt}, '0);

        // Stream enough TLPs to wrap the counter
        do_reset();
        bus.tlp_ready_i = 1'b1;
        begin
            int k = 0;
            for (int t = 0; t < 4 * (2 ** TB_CNT_W) && k < (2 ** TB_CNT_W) + 2; t++) begin
                drive_rand();
                tick();
                if (acc) k++;
            end
            if (k < (2 ** TB_CNT_W) + 2) fail("stream_timeout");
        end
        drain(10);
        chk("wrap_cnt", {1016'd0, tlp_cnt}, 1024'd2);
        chk("stream_in_out", 1024'(n_out), 1024'((2 ** TB_CNT_W) + 2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
